// File: rtl/bp_pht_scheduler_if.sv
// ---------------------------------------------------------------------------
// bp_pht_scheduler_if
// Bundles the three buses the PHT scheduler talks on:
//   pred_* : fetch-stage predict request and the prediction returned
//   upd_*  : execute-stage resolve updates (valid/ready handshake)
//   tbl_*  : single-ported synchronous PHT RAM access
// Modports:
//   master : the environment (fetch, execute, RAM) driving the scheduler
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface bp_pht_scheduler_if #(
  parameter int INDEX_W = 12
);
  logic               pred_req;
  logic [31:0]        pred_pc;
  logic               pred_ack;
  logic               pred_valid;
  logic               pred_taken;
  logic [1:0]         pred_ctr;
  logic [INDEX_W-1:0] pred_idx;
  logic [INDEX_W-1:0] pred_ghist;

  logic               upd_valid;
  logic               upd_ready;
  logic [INDEX_W-1:0] upd_idx;
  logic [1:0]         upd_ctr;
  logic [INDEX_W-1:0] upd_ghist;
  logic               upd_taken;
  logic               upd_mispredict;

  logic               tbl_en;
  logic               tbl_we;
  logic [INDEX_W-1:0] tbl_addr;
  logic [1:0]         tbl_wdata;
  logic [1:0]         tbl_rdata;

  modport master (
    output pred_req, pred_pc,
    input  pred_ack, pred_valid, pred_taken, pred_ctr, pred_idx, pred_ghist,
    output upd_valid, upd_idx, upd_ctr, upd_ghist, upd_taken, upd_mispredict,
    input  upd_ready,
    input  tbl_en, tbl_we, tbl_addr, tbl_wdata,
    output tbl_rdata
  );

  modport slave (
    input  pred_req, pred_pc,
    output pred_ack, pred_valid, pred_taken, pred_ctr, pred_idx, pred_ghist,
    input  upd_valid, upd_idx, upd_ctr, upd_ghist, upd_taken, upd_mispredict,
    output upd_ready,
    output tbl_en, tbl_we, tbl_addr, tbl_wdata,
    input  tbl_rdata
  );
endinterface

// File: rtl/bp_pht_scheduler.sv
// ---------------------------------------------------------------------------
// bp_pht_scheduler
// Sequences a single-ported gshare PHT of 2-bit saturating counters held in
// an external synchronous RAM. After reset the whole table is written with
// INIT_CTR; afterwards each cycle carries at most one PHT op, chosen between
// fetch predict reads and buffered resolve-update writes. Also owns the
// speculative global history and repairs it on a mispredict.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : pred_*, upd_*, tbl_* buses (see bp_pht_scheduler_if)
//   ghist       : current speculative global history
//   init_done   : table initialisation finished (sticky until reset)
// ---------------------------------------------------------------------------
module bp_pht_scheduler #(
  parameter int         INDEX_W    = 12,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_CTR   = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset,
  bp_pht_scheduler_if.slave     bus,
  output logic [INDEX_W-1:0]    ghist,
  output logic                  init_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [INDEX_W-1:0] IDX_ZERO  = {INDEX_W{1'b0}};
  localparam logic [INDEX_W-1:0] IDX_LAST  = {INDEX_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ZERO  = {PTR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Saturating 2-bit counter step towards the resolved outcome.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  state_t             state_r, state_next_s;
  logic [INDEX_W-1:0] init_ptr_r;
  logic               init_done_r;

  logic [INDEX_W-1:0] fifo_idx_r [FIFO_DEPTH];
  logic [1:0]         fifo_ctr_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic [INDEX_W-1:0] ghist_r, ghist_next_s;
  logic               pred_valid_r;
  logic [INDEX_W-1:0] pred_idx_r, pred_ghist_r;

  logic               upd_ready_s, push_s, pop_s, misp_acc_s, rd_s;
  logic [INDEX_W-1:0] idx_s;
  logic               tbl_en_s, tbl_we_s;
  logic [INDEX_W-1:0] tbl_addr_s;
  logic [1:0]         tbl_wdata_s;
  logic               unused_s;

  // Handshake qualification: updates are only taken while running.
  always_comb begin
    upd_ready_s = 1'b0;
    if (state_r == ST_RUN) begin
      upd_ready_s = (count_r < DEPTH_C);
    end else begin
      upd_ready_s = 1'b0;
    end
    push_s     = bus.upd_valid & upd_ready_s;
    misp_acc_s = push_s & bus.upd_mispredict;
  end

  // Next history: a mispredict repair beats the speculative shift; the read
  // index is formed from this value so a request meeting pred_valid already
  // sees the shifted history.
  always_comb begin
    ghist_next_s = ghist_r;
    if (misp_acc_s) begin
      ghist_next_s = {bus.upd_ghist[INDEX_W-2:0], bus.upd_taken};
    end else if (pred_valid_r) begin
      ghist_next_s = {ghist_r[INDEX_W-2:0], bus.tbl_rdata[1]};
    end else begin
      ghist_next_s = ghist_r;
    end
    idx_s = bus.pred_pc[INDEX_W+1:2] ^ ghist_next_s;
  end

  // Next-state and PHT port arbitration: full FIFO drains first so fetch
  // cannot starve updates, then predicts, then opportunistic drains.
  always_comb begin
    state_next_s = state_r;
    tbl_en_s     = 1'b0;
    tbl_we_s     = 1'b0;
    tbl_addr_s   = IDX_ZERO;
    tbl_wdata_s  = 2'b00;
    pop_s        = 1'b0;
    rd_s         = 1'b0;
    case (state_r)
      ST_INIT: begin
        tbl_en_s    = 1'b1;
        tbl_we_s    = 1'b1;
        tbl_addr_s  = init_ptr_r;
        tbl_wdata_s = INIT_CTR;
        if (init_ptr_r == IDX_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (count_r == DEPTH_C) begin
          pop_s = 1'b1;
        end else if (bus.pred_req && !misp_acc_s) begin
          rd_s = 1'b1;
        end else if (count_r != CNT_ZERO) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
        if (pop_s) begin
          tbl_en_s    = 1'b1;
          tbl_we_s    = 1'b1;
          tbl_addr_s  = fifo_idx_r[rd_ptr_r];
          tbl_wdata_s = fifo_ctr_r[rd_ptr_r];
        end else if (rd_s) begin
          tbl_en_s    = 1'b1;
          tbl_we_s    = 1'b0;
          tbl_addr_s  = idx_s;
        end else begin
          tbl_en_s    = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // State register, init sweep pointer and sticky init-done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      init_ptr_r  <= IDX_ZERO;
      init_done_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_INIT) begin
        init_ptr_r <= init_ptr_r + INDEX_W'(1'b1);
        if (init_ptr_r == IDX_LAST) begin
          init_done_r <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage holds the already-updated counter; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_idx_r[wr_ptr_r] <= bus.upd_idx;
      fifo_ctr_r[wr_ptr_r] <= ctr_update(bus.upd_ctr, bus.upd_taken);
    end
  end

  // History and prediction tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghist_r      <= IDX_ZERO;
      pred_valid_r <= 1'b0;
      pred_idx_r   <= IDX_ZERO;
      pred_ghist_r <= IDX_ZERO;
    end else begin
      ghist_r      <= ghist_next_s;
      pred_valid_r <= rd_s;
      if (rd_s) begin
        pred_idx_r   <= idx_s;
        pred_ghist_r <= ghist_next_s;
      end
    end
  end

  // The counter arrives straight from the RAM in the pred_valid cycle, so it
  // is gated rather than registered to keep the one-cycle read latency.
  assign bus.pred_ack   = rd_s;
  assign bus.pred_valid = pred_valid_r;
  assign bus.pred_ctr   = pred_valid_r ? bus.tbl_rdata : 2'b00;
  assign bus.pred_taken = pred_valid_r & bus.tbl_rdata[1];
  assign bus.pred_idx   = pred_idx_r;
  assign bus.pred_ghist = pred_ghist_r;
  assign bus.upd_ready  = upd_ready_s;
  assign bus.tbl_en     = tbl_en_s;
  assign bus.tbl_we     = tbl_we_s;
  assign bus.tbl_addr   = tbl_addr_s;
  assign bus.tbl_wdata  = tbl_wdata_s;
  assign ghist          = ghist_r;
  assign init_done      = init_done_r;

  assign unused_s = ^{bus.pred_pc[31:INDEX_W+2], bus.pred_pc[1:0], bus.upd_ghist[INDEX_W-1]};

endmodule

// File: doc/bp_pht_scheduler.md
Name: bp_pht_scheduler

Overview:
- Sequences a single-ported pattern history table (PHT) of 2-bit saturating counters for the gshare predictor; the PHT itself is an external synchronous RAM.
- Arbitrates each cycle between fetch-stage predict lookups and execute-stage resolve updates, which are buffered in a small FIFO.
- Owns the speculative global history register, repairs it on mispredict, and initialises the whole table after reset.

Parameters:
- INDEX_W, 12, PHT index width; table has 2^INDEX_W entries.
- FIFO_DEPTH, 4, resolve-update FIFO entries (power of 2, ≥2).
- INIT_CTR, 2'b10, counter value written to every entry during init.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_req  in  1  fetch requests a prediction this cycle
- pred_pc  in  32  PC of the branch to predict
- pred_ack  out  1  request accepted; PHT read issued this cycle
- pred_valid  out  1  prediction result valid (1 cycle after pred_ack)
- pred_taken  out  1  tbl_rdata[1] when pred_valid
- pred_ctr  out  2  raw counter read
- pred_idx  out  INDEX_W  index used for the read
- pred_ghist  out  INDEX_W  history used to form pred_idx
- upd_valid  in  1  resolve update offered
- upd_ready  out  1  FIFO can accept
- upd_idx  in  INDEX_W  index returned with the original prediction
- upd_ctr  in  2  counter value returned with the original prediction
- upd_ghist  in  INDEX_W  history returned with the original prediction
- upd_taken  in  1  actual outcome
- upd_mispredict  in  1  outcome differed from prediction
- tbl_en  out  1  PHT access this cycle
- tbl_we  out  1  1 = write, 0 = read
- tbl_addr  out  INDEX_W  PHT address
- tbl_wdata  out  2  write data
- tbl_rdata  in  2  read data, valid the cycle after a read
- ghist  out  INDEX_W  current speculative global history
- init_done  out  1  table initialisation complete

Behaviour:
- Reset: state INIT, init pointer 0, FIFO empty, ghist 0. pred_ack, pred_valid, upd_ready and init_done are 0. pred_* data outputs are 0.
- Reset mid-operation has the same effect: the FIFO contents are dropped, an outstanding read yields no pred_valid, and init restarts.
- INIT: each cycle tbl_en=1, tbl_we=1, tbl_addr=ptr, tbl_wdata=INIT_CTR, ptr+1. After writing entry 2^INDEX_W−1, go to RUN and set init_done=1, which stays 1 until reset. pred_ack=0 and upd_ready=0 throughout INIT.
- RUN: upd_ready = (count < FIFO_DEPTH). A push occurs on upd_valid & upd_ready and stores upd_idx with new counter = upd_taken ? min(upd_ctr+1,3) : max(upd_ctr−1,0).
- RUN arbitration, exactly one PHT op per cycle, priority order:
  (1) FIFO full → pop the head and write it; pred_ack=0.
  (2) pred_req and no mispredict accepted this cycle → read; pred_ack=1.
  (3) FIFO non-empty → pop and write.
  (4) Otherwise tbl_en=0.
- A push and a pop in the same cycle leave count unchanged.
- Read index: idx = pred_pc[INDEX_W+1:2] ^ hsrc, where hsrc = bypassed next history (see below). pred_idx and pred_ghist register idx and hsrc.
- Read latency 1: in the cycle after pred_ack, pred_valid=1, pred_ctr=tbl_rdata, pred_taken=tbl_rdata[1]. Back-to-back acks give back-to-back pred_valid.
- History, evaluated in this priority order:
  - On an accepted update with upd_mispredict=1: ghist ← {upd_ghist[INDEX_W−2:0], upd_taken}. This overrides any same-cycle speculative shift.
  - Else if pred_valid: ghist ← {ghist[INDEX_W−2:0], tbl_rdata[1]}.
  - Else hold.
- hsrc equals the ghist value being written this cycle. A pred_req coinciding with pred_valid therefore uses the already-shifted history.
- In a mispredict-acceptance cycle pred_ack=0. A pred_valid in that same cycle is still presented, and fetch discards it.
- Reads do not check the FIFO for pending writes to the same index; a stale counter is acceptable.

Test Plan:
- Init: reset for 1 cycle, INDEX_W=4 → exactly 16 writes of 2'b10 to addresses 0..15, then init_done=1 on cycle 17; no pred_ack or upd_ready before that.
- Predict: ghist=0, pred_pc=0x0000_0010 → tbl_addr=4, pred_ack=1; next cycle pred_valid=1, pred_taken=1, ghist=0x001.
- Back-to-back: predicts at pc 0x10 then 0x20 on consecutive cycles, first reads taken → second tbl_addr = 8 ^ 0x001 = 9, pred_ghist=0x001.
- FIFO full: push 4 updates while pred_req is held high → upd_ready=0; the next cycle gives pred_ack=0 and a write of entry 0. Check saturation: upd_ctr=3 with taken writes 3; upd_ctr=0 with not-taken writes 0.
- Mispredict: upd_mispredict=1, upd_ghist=0x0A5, upd_taken=0, coinciding with pred_valid taken → ghist=0x14A, and pred_ack=0 that cycle.
- Reset mid-run: assert reset while count=3 with a read outstanding → no pred_valid, FIFO empty, INIT restarts at address 0.
